pin_collision_engine: RTL and testbench
=======================================

Name: pin_collision_engine

Overview:
- Parametrised, time-multiplexed collision resolver for the bowling physics frame.
- Accepts a snapshot of ball and N_PINS pin positions/velocities via valid/ready. Sweeps ball-vs-pin, then every pin pair, through one pipelined squared-distance unit.
- Returns updated pin velocities and a sticky hit mask, then pulses done.
- Sits between the position integrator and the frame-update logic, once per frame.

Parameters:
N_PINS, 10, number of pins (2..16)
X_W, 11, x coordinate width (unsigned)
Y_W, 10, y coordinate width (unsigned)
V_W, 16, velocity component width (two's complement)
BALL_RADIUS, 39, ball radius in pixels
PIN_RADIUS, 21, pin radius in pixels
SCREEN_WIDTH, 1024, pins with x >= this are off-lane
SCREEN_HEIGHT, 768, pins with y >= this are off-lane
BALL_XFER_SHIFT, 0, arithmetic right shift applied to ball velocity on transfer to a pin

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
valid_in  in  1  frame snapshot valid
ready_out  out  1  engine idle, can accept a frame
hit_clear_in  in  1  clears pins_hit (sampled only in IDLE)
ball_x  in  X_W  ball centre x
ball_y  in  Y_W  ball centre y
ball_vx_in  in  V_W  ball velocity x
ball_vy_in  in  V_W  ball velocity y
pins_x  in  N_PINS*X_W  pin centre x, packed
pins_y  in  N_PINS*Y_W  pin centre y, packed
pins_vx_in  in  N_PINS*V_W  pin velocity x
pins_vy_in  in  N_PINS*V_W  pin velocity y
pins_vx_out  out  N_PINS*V_W  resolved pin velocity x
pins_vy_out  out  N_PINS*V_W  resolved pin velocity y
pins_hit  out  N_PINS  sticky per-pin hit flags
done  out  1  one-cycle pulse, outputs valid

Behaviour:
- Clock clk_in, reset rst_in: single clock domain; reset synchronous, active-high.
- Reset: pins_vx_out=0, pins_vy_out=0, pins_hit=0, done=0, FSM=IDLE. ready_out=0 during the reset cycle, 1 from the next cycle.
- Reset mid-frame aborts the frame immediately. No done is pulsed for the aborted frame.
- FSM states: IDLE -> BALL -> PAIR -> DRAIN -> IDLE.
- Accept: valid_in && ready_out in IDLE at cycle 0.
  - Capture all inputs into working registers.
  - Working velocities = pins_v*_in.
  - ready_out drops next cycle.
  - valid_in while busy is ignored. Inputs may change after accept.
- BALL: cycles 1..N_PINS issue pin k=0..N_PINS-1.
- PAIR: next P=N_PINS*(N_PINS-1)/2 cycles issue (i,j), i<j, in order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
  - Generated by i/j counters: when j==N-1, i++ and j=i+2.
- Pipeline: stage 1 registers the squared distance and the on-lane flags. Stage 2, next cycle, compares and commits.
  - Stage 1 reads positions only; stage 2 reads and writes working velocities. There is no hazard and no forwarding.
- DRAIN: final commit cycle. Working velocities go to the outputs and done=1 at cycle N_PINS+P+2 (57 for N=10).
- ready_out is back to 1 in the same cycle as done.
- Outputs hold until the next done or reset.
- Arithmetic:
  - dx = signed(X_W+1) difference; dy = signed(Y_W+1) difference.
  - d2 = dx^2 + dy^2 at width 2*max(X_W,Y_W)+3. No truncation.
- Ball hit rule: d2 <= (BALL_RADIUS+PIN_RADIUS)^2, inclusive, and the pin is on-lane.
  - Action: pin working v = ball_v >>> BALL_XFER_SHIFT, and pins_hit[k] set.
- Pair hit rule: d2 <= (2*PIN_RADIUS)^2, inclusive, and both pins on-lane.
  - Action: swap the working velocities of i and j; set pins_hit[i] and pins_hit[j].
  - Swaps chain sequentially in pair order: a later pair sees earlier results.
- pins_hit is sticky across frames. hit_clear_in in IDLE zeros it.
  - hit_clear_in coinciding with accept: clear first, then frame hits accumulate.
- Off-lane pins keep their input velocity unless changed through an on-lane partner. That cannot occur, since both pins must be on-lane.

Decomposition:
- Package collision_pkg holds:
  - default constants: radii, screen size, N_PINS;
  - derived thresholds BALL_HIT_D2 and PIN_HIT_D2;
  - typedefs coord_x_t, coord_y_t, vel_t, dist2_t;
  - FSM state enum.
- One sub-module, dist_sq_unit: registered squared-distance stage, with on-lane flag outputs.

Test Plan:
- Ball (100,100) v(5,-8); pin0 (130,140), d2=2500; other pins far apart on-lane at 100 px spacing -> done at cycle 57, pin0 v=(5,-8), pins_hit=10'b0000000001.
- Boundary: pin0 at (136,148), d2=3600 -> hit. Repeat with pin0 at (137,148), d2=3673 -> no hit, v unchanged, pins_hit=0.
- Pair: pin1 (300,300) v(2,0), pin2 (342,300) v(-3,1), d2=1764 -> pin1 v=(-3,1), pin2 v=(2,0), hits bits 1,2. At 343 apart -> no swap.
- Chain: ball hits pin0 with v(5,-8); pin0 touches pin1 v(1,1) -> pin1=(5,-8), pin0=(1,1), hits bits 0,1.
- Off-lane: pin3 x=1100 overlapping pin4 -> no swap, no hit bits. Sticky: pins_hit persists over the next frame until hit_clear_in in IDLE zeroes it.
- Control: valid_in held during busy -> single frame processed. rst_in at cycle 20 -> all outputs 0, no done, ready_out=1 the cycle after reset; the next frame completes normally.

Source files
------------

// File: rtl/collision_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared constants, types and helpers for the pin collision engine.
//   - default geometry (pin count, widths, radii, lane size, transfer shift)
//   - derived hit thresholds on squared centre distance
//   - coordinate / velocity / distance typedefs at the default widths
//   - FSM state encoding
// -----------------------------------------------------------------------------
package collision_pkg;

  localparam int DEF_N_PINS          = 10;
  localparam int DEF_X_W             = 11;
  localparam int DEF_Y_W             = 10;
  localparam int DEF_V_W             = 16;
  localparam int DEF_BALL_RADIUS     = 39;
  localparam int DEF_PIN_RADIUS      = 21;
  localparam int DEF_SCREEN_WIDTH    = 1024;
  localparam int DEF_SCREEN_HEIGHT   = 768;
  localparam int DEF_BALL_XFER_SHIFT = 0;

  // Width that holds dx^2 + dy^2 of two unsigned coordinates without truncation.
  function automatic int d2_width(input int xw, input int yw);
    return 2 * ((xw > yw) ? xw : yw) + 3;
  endfunction

  localparam int DEF_D2_W   = d2_width(DEF_X_W, DEF_Y_W);
  localparam int BALL_HIT_D2 = (DEF_BALL_RADIUS + DEF_PIN_RADIUS) * (DEF_BALL_RADIUS + DEF_PIN_RADIUS);
  localparam int PIN_HIT_D2  = (2 * DEF_PIN_RADIUS) * (2 * DEF_PIN_RADIUS);

  typedef logic        [DEF_X_W-1:0]   coord_x_t;
  typedef logic        [DEF_Y_W-1:0]   coord_y_t;
  typedef logic signed [DEF_V_W-1:0]   vel_t;
  typedef logic        [DEF_D2_W-1:0]  dist2_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BALL,
    S_PAIR,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/pin_collision_engine_if.sv
// -----------------------------------------------------------------------------
// pin_collision_engine_if
// Frame snapshot handshake and result bus of the collision engine.
//   master (frame producer): drives valid_in, hit_clear_in, ball/pin state;
//                            observes ready_out, resolved velocities, hits, done
//   slave  (engine)        : the opposite directions
// -----------------------------------------------------------------------------
interface pin_collision_engine_if
  import collision_pkg::*;
#(
  parameter int N_PINS = DEF_N_PINS,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int V_W    = DEF_V_W
);
  logic                    valid_in;
  logic                    ready_out;
  logic                    hit_clear_in;
  logic [X_W-1:0]          ball_x;
  logic [Y_W-1:0]          ball_y;
  logic [V_W-1:0]          ball_vx_in;
  logic [V_W-1:0]          ball_vy_in;
  logic [N_PINS*X_W-1:0]   pins_x;
  logic [N_PINS*Y_W-1:0]   pins_y;
  logic [N_PINS*V_W-1:0]   pins_vx_in;
  logic [N_PINS*V_W-1:0]   pins_vy_in;
  logic [N_PINS*V_W-1:0]   pins_vx_out;
  logic [N_PINS*V_W-1:0]   pins_vy_out;
  logic [N_PINS-1:0]       pins_hit;
  logic                    done;

  modport master (
    output valid_in, hit_clear_in, ball_x, ball_y, ball_vx_in, ball_vy_in,
           pins_x, pins_y, pins_vx_in, pins_vy_in,
    input  ready_out, pins_vx_out, pins_vy_out, pins_hit, done
  );

  modport slave (
    input  valid_in, hit_clear_in, ball_x, ball_y, ball_vx_in, ball_vy_in,
           pins_x, pins_y, pins_vx_in, pins_vy_in,
    output ready_out, pins_vx_out, pins_vy_out, pins_hit, done
  );
endinterface

// File: rtl/pin_collision_engine_dist_sq_unit.sv
// -----------------------------------------------------------------------------
// dist_sq_unit
// Registered squared-distance stage between points a and b, plus registered
// on-lane flags for each point.
//   clk_in, rst_in   : clock, synchronous active-high reset
//   i_ax/i_ay        : point a (unsigned)
//   i_bx/i_by        : point b (unsigned)
//   o_d2             : (ax-bx)^2 + (ay-by)^2, one cycle later, full width
//   o_a_on / o_b_on  : point lies inside the lane (x < width, y < height)
// -----------------------------------------------------------------------------
module dist_sq_unit
  import collision_pkg::*;
#(
  parameter  int X_W           = DEF_X_W,
  parameter  int Y_W           = DEF_Y_W,
  parameter  int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter  int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  localparam int D2_W          = d2_width(X_W, Y_W)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [X_W-1:0]  i_ax,
  input  logic [Y_W-1:0]  i_ay,
  input  logic [X_W-1:0]  i_bx,
  input  logic [Y_W-1:0]  i_by,
  output logic [D2_W-1:0] o_d2,
  output logic            o_a_on,
  output logic            o_b_on
);
  logic signed [X_W:0]    w_dx;
  logic signed [Y_W:0]    w_dy;
  logic signed [D2_W-1:0] w_dx_e;
  logic signed [D2_W-1:0] w_dy_e;
  logic        [D2_W-1:0] w_d2;

  // One extra bit keeps the unsigned difference exact as a signed value.
  assign w_dx   = $signed({1'b0, i_ax}) - $signed({1'b0, i_bx});
  assign w_dy   = $signed({1'b0, i_ay}) - $signed({1'b0, i_by});
  assign w_dx_e = D2_W'(w_dx);
  assign w_dy_e = D2_W'(w_dy);
  assign w_d2   = D2_W'(w_dx_e * w_dx_e + w_dy_e * w_dy_e);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      o_d2   <= '0;
      o_a_on <= 1'b0;
      o_b_on <= 1'b0;
    end else begin
      o_d2   <= w_d2;
      o_a_on <= (int'(i_ax) < SCREEN_WIDTH) && (int'(i_ay) < SCREEN_HEIGHT);
      o_b_on <= (int'(i_bx) < SCREEN_WIDTH) && (int'(i_by) < SCREEN_HEIGHT);
    end
  end
endmodule

// File: rtl/pin_collision_engine.sv
// -----------------------------------------------------------------------------
// pin_collision_engine
// Time-multiplexed collision resolver: one frame snapshot in, ball-vs-pin sweep
// then all pin pairs through one two-stage squared-distance pipeline, resolved
// pin velocities and sticky hit mask out with a one-cycle done pulse.
//   clk_in : system clock
//   rst_in : synchronous active-high reset (aborts a frame in flight)
//   bus    : slave side of pin_collision_engine_if
//            valid_in/ready_out handshake, hit_clear_in, ball and pin inputs,
//            pins_vx_out/pins_vy_out, pins_hit, done
// -----------------------------------------------------------------------------
module pin_collision_engine
  import collision_pkg::*;
#(
  parameter int N_PINS          = DEF_N_PINS,
  parameter int X_W             = DEF_X_W,
  parameter int Y_W             = DEF_Y_W,
  parameter int V_W             = DEF_V_W,
  parameter int BALL_RADIUS     = DEF_BALL_RADIUS,
  parameter int PIN_RADIUS      = DEF_PIN_RADIUS,
  parameter int SCREEN_WIDTH    = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT   = DEF_SCREEN_HEIGHT,
  parameter int BALL_XFER_SHIFT = DEF_BALL_XFER_SHIFT
) (
  input logic                 clk_in,
  input logic                 rst_in,
  pin_collision_engine_if.slave bus
);
  localparam int D2_W  = d2_width(X_W, Y_W);
  localparam int IDX_W = (N_PINS > 1) ? $clog2(N_PINS) : 1;
  localparam logic [D2_W-1:0]  L_BALL_D2 = D2_W'((BALL_RADIUS + PIN_RADIUS) * (BALL_RADIUS + PIN_RADIUS));
  localparam logic [D2_W-1:0]  L_PIN_D2  = D2_W'(4 * PIN_RADIUS * PIN_RADIUS);
  localparam logic [IDX_W-1:0] L_LAST    = IDX_W'(N_PINS - 1);
  localparam logic [IDX_W-1:0] L_LAST_I  = IDX_W'(N_PINS - 2);

  state_t r_state, w_state_next;

  // Frame working copy (positions, ball, evolving pin velocities).
  logic        [X_W-1:0] r_px  [N_PINS];
  logic        [Y_W-1:0] r_py  [N_PINS];
  logic signed [V_W-1:0] r_wvx [N_PINS];
  logic signed [V_W-1:0] r_wvy [N_PINS];
  logic signed [V_W-1:0] w_nvx [N_PINS];
  logic signed [V_W-1:0] w_nvy [N_PINS];
  logic        [X_W-1:0] r_bx;
  logic        [Y_W-1:0] r_by;
  logic signed [V_W-1:0] r_bvx, r_bvy;

  logic [IDX_W-1:0] r_k, r_i, r_j;
  logic             w_accept, w_issue, w_issue_ball;
  logic [IDX_W-1:0] w_ia, w_ib;
  logic [X_W-1:0]   w_ax;
  logic [Y_W-1:0]   w_ay;

  // Stage-1 tag travelling alongside the registered distance.
  logic             r_s1_valid, r_s1_ball;
  logic [IDX_W-1:0] r_s1_a, r_s1_b;
  logic [D2_W-1:0]  w_d2;
  logic             w_a_on, w_b_on;

  logic [N_PINS-1:0]     r_hit, w_hit_next;
  logic [N_PINS*V_W-1:0] r_vx_out, r_vy_out;
  logic                  r_done;

  assign bus.ready_out   = (r_state == S_IDLE) && !rst_in;
  assign bus.pins_vx_out = r_vx_out;
  assign bus.pins_vy_out = r_vy_out;
  assign bus.pins_hit    = r_hit;
  assign bus.done        = r_done;
  assign w_accept        = bus.valid_in && bus.ready_out;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_ball = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_BALL;
      S_BALL: begin
        w_issue      = 1'b1;
        w_issue_ball = 1'b1;
        if (r_k == L_LAST) w_state_next = S_PAIR;
      end
      S_PAIR: begin
        w_issue = 1'b1;
        if (r_i == L_LAST_I && r_j == L_LAST) w_state_next = S_DRAIN;
      end
      S_DRAIN: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Ball sweep uses the ball as point a; pair sweep uses pin i.
  assign w_ia = w_issue_ball ? '0 : r_i;
  assign w_ib = w_issue_ball ? r_k : r_j;
  assign w_ax = w_issue_ball ? r_bx : r_px[r_i];
  assign w_ay = w_issue_ball ? r_by : r_py[r_i];

  dist_sq_unit #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_dist (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_ax   (w_ax),
    .i_ay   (w_ay),
    .i_bx   (r_px[w_ib]),
    .i_by   (r_py[w_ib]),
    .o_d2   (w_d2),
    .o_a_on (w_a_on),
    .o_b_on (w_b_on)
  );

  // Stage 2: compare and resolve. A clear in IDLE lands before any frame hit
  // because the pipeline is empty whenever the engine is idle.
  always_comb begin
    w_nvx      = r_wvx;
    w_nvy      = r_wvy;
    w_hit_next = r_hit;
    if (r_state == S_IDLE && bus.hit_clear_in) w_hit_next = '0;
    if (r_s1_valid) begin
      if (r_s1_ball) begin
        if (w_b_on && w_d2 <= L_BALL_D2) begin
          w_nvx[r_s1_b]      = r_bvx >>> BALL_XFER_SHIFT;
          w_nvy[r_s1_b]      = r_bvy >>> BALL_XFER_SHIFT;
          w_hit_next[r_s1_b] = 1'b1;
        end
      end else if (w_a_on && w_b_on && w_d2 <= L_PIN_D2) begin
        w_nvx[r_s1_a]      = r_wvx[r_s1_b];
        w_nvy[r_s1_a]      = r_wvy[r_s1_b];
        w_nvx[r_s1_b]      = r_wvx[r_s1_a];
        w_nvy[r_s1_b]      = r_wvy[r_s1_a];
        w_hit_next[r_s1_a] = 1'b1;
        w_hit_next[r_s1_b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_s1_valid <= 1'b0;
      r_hit      <= '0;
      r_vx_out   <= '0;
      r_vy_out   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_s1_valid <= w_issue;
      r_s1_ball  <= w_issue_ball;
      r_s1_a     <= w_ia;
      r_s1_b     <= w_ib;
      r_hit      <= w_hit_next;
      r_done     <= 1'b0;
      unique case (r_state)
        S_IDLE: r_k <= '0;
        S_BALL: begin
          r_k <= r_k + IDX_W'(1);
          r_i <= '0;
          r_j <= IDX_W'(1);
        end
        S_PAIR: begin
          // Row walk: after the last partner of i, restart one past the next i.
          if (r_j == L_LAST) begin
            r_i <= r_i + IDX_W'(1);
            r_j <= r_i + IDX_W'(2);
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          r_done <= 1'b1;
          for (int k = 0; k < N_PINS; k++) begin
            r_vx_out[k*V_W +: V_W] <= w_nvx[k];
            r_vy_out[k*V_W +: V_W] <= w_nvy[k];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the working arrays carry no reset; they are fully reloaded on every
  // accept and nothing observes them before that.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_bx  <= bus.ball_x;
      r_by  <= bus.ball_y;
      r_bvx <= bus.ball_vx_in;
      r_bvy <= bus.ball_vy_in;
      for (int k = 0; k < N_PINS; k++) begin
        r_px[k]  <= bus.pins_x[k*X_W +: X_W];
        r_py[k]  <= bus.pins_y[k*Y_W +: Y_W];
        r_wvx[k] <= bus.pins_vx_in[k*V_W +: V_W];
        r_wvy[k] <= bus.pins_vy_in[k*V_W +: V_W];
      end
    end else begin
      r_wvx <= w_nvx;
      r_wvy <= w_nvy;
    end
  end
endmodule

// File: tb/tb_pin_collision_engine.sv
// -----------------------------------------------------------------------------
// tb_pin_collision_engine
// Directed and randomized frames against a behavioural model of the collision
// rules (integer geometry, sequential ball sweep then ordered pair sweep).
// -----------------------------------------------------------------------------
module tb_pin_collision_engine;
  import collision_pkg::*;

  localparam int N   = DEF_N_PINS;
  localparam int X_W = DEF_X_W;
  localparam int Y_W = DEF_Y_W;
  localparam int V_W = DEF_V_W;
  localparam int P   = N * (N - 1) / 2;
  localparam int LAT = N + P + 2;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  pin_collision_engine_if #(.N_PINS(N), .X_W(X_W), .Y_W(Y_W), .V_W(V_W)) bus ();

  pin_collision_engine #(.N_PINS(N), .X_W(X_W), .Y_W(Y_W), .V_W(V_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Current frame description.
  int b_x, b_y, b_vx, b_vy;
  int p_x [N];
  int p_y [N];
  int p_vx[N];
  int p_vy[N];

  // Reference model state.
  int exp_vx[N];
  int exp_vy[N];
  logic [N-1:0] exp_hit;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit on_lane(input int x, input int y);
    return (x < DEF_SCREEN_WIDTH) && (y < DEF_SCREEN_HEIGHT);
  endfunction

  function automatic int dist2(input int ax, input int ay, input int bx, input int by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
  endfunction

  // Physics rules applied in frame order: ball against each pin, then pairs.
  task automatic model_frame(input bit clear);
    int t;
    if (clear) exp_hit = '0;
    for (int k = 0; k < N; k++) begin
      exp_vx[k] = p_vx[k];
      exp_vy[k] = p_vy[k];
    end
    for (int k = 0; k < N; k++)
      if (on_lane(p_x[k], p_y[k]) && dist2(b_x, b_y, p_x[k], p_y[k]) <= BALL_HIT_D2) begin
        exp_vx[k]  = b_vx >>> DEF_BALL_XFER_SHIFT;
        exp_vy[k]  = b_vy >>> DEF_BALL_XFER_SHIFT;
        exp_hit[k] = 1'b1;
      end
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++)
        if (on_lane(p_x[i], p_y[i]) && on_lane(p_x[j], p_y[j]) &&
            dist2(p_x[i], p_y[i], p_x[j], p_y[j]) <= PIN_HIT_D2) begin
          t = exp_vx[i]; exp_vx[i] = exp_vx[j]; exp_vx[j] = t;
          t = exp_vy[i]; exp_vy[i] = exp_vy[j]; exp_vy[j] = t;
          exp_hit[i] = 1'b1;
          exp_hit[j] = 1'b1;
        end
  endtask

  task automatic set_default();
    b_x = 100; b_y = 100; b_vx = 5; b_vy = -8;
    for (int k = 0; k < N; k++) begin
      p_x[k]  = 50 + 100 * k;
      p_y[k]  = 500;
      p_vx[k] = k + 1;
      p_vy[k] = -(k + 1);
    end
  endtask

  task automatic apply_inputs();
    bus.ball_x     = X_W'(b_x);
    bus.ball_y     = Y_W'(b_y);
    bus.ball_vx_in = V_W'(b_vx);
    bus.ball_vy_in = V_W'(b_vy);
    for (int k = 0; k < N; k++) begin
      bus.pins_x[k*X_W +: X_W]     = X_W'(p_x[k]);
      bus.pins_y[k*Y_W +: Y_W]     = Y_W'(p_y[k]);
      bus.pins_vx_in[k*V_W +: V_W] = V_W'(p_vx[k]);
      bus.pins_vy_in[k*V_W +: V_W] = V_W'(p_vy[k]);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N*V_W-1:0] evx, evy;
    for (int k = 0; k < N; k++) begin
      evx[k*V_W +: V_W] = V_W'(exp_vx[k]);
      evy[k*V_W +: V_W] = V_W'(exp_vy[k]);
    end
    check({tag, "/vx"}, bus.pins_vx_out, evx);
    check({tag, "/vy"}, bus.pins_vy_out, evy);
    check({tag, "/hit"}, bus.pins_hit, exp_hit);
  endtask

  // Called at a falling edge with the engine idle; returns one cycle after done.
  task automatic run_frame(input string tag, input bit clear, input bit hold_valid);
    int cyc;
    bit seen;
    apply_inputs();
    bus.valid_in     = 1'b1;
    bus.hit_clear_in = clear;
    check({tag, "/ready_c0"}, bus.ready_out, 1'b1);
    model_frame(clear);
    @(negedge clk_in);
    if (!hold_valid) bus.valid_in = 1'b0;
    bus.hit_clear_in = 1'b0;
    bus.ball_x       = X_W'($urandom);
    bus.pins_x       = {N{X_W'($urandom)}};
    bus.pins_vx_in   = {N{V_W'($urandom)}};
    check({tag, "/ready_c1"}, bus.ready_out, 1'b0);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < LAT + 20) begin
      @(negedge clk_in);
      cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.valid_in = 1'b0;
    check({tag, "/done_cycle"}, seen ? cyc : -1, LAT);
    check({tag, "/ready_done"}, bus.ready_out, 1'b1);
    check_outputs(tag);
    @(negedge clk_in);
    check({tag, "/done_pulse"}, bus.done, 1'b0);
    check_outputs({tag, "/hold"});
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int hits = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_in);
      if (bus.done === 1'b1) hits++;
    end
    check({tag, "/no_done"}, hits, 0);
  endtask

  initial begin
    rst_in           = 1'b1;
    bus.valid_in     = 1'b0;
    bus.hit_clear_in = 1'b0;
    set_default();
    apply_inputs();
    exp_hit = '0;

    // Reset state.
    repeat (2) @(negedge clk_in);
    check("rst/ready", bus.ready_out, 1'b0);
    check("rst/done", bus.done, 1'b0);
    check("rst/vx", bus.pins_vx_out, '0);
    check("rst/vy", bus.pins_vy_out, '0);
    check("rst/hit", bus.pins_hit, '0);
    rst_in = 1'b0;
    #1 check("rst/ready_after", bus.ready_out, 1'b1);

    // Ball hits pin0 at d2 = 2500.
    set_default();
    p_x[0] = 130; p_y[0] = 140;
    run_frame("ball", 1'b0, 1'b0);

    // Ball boundary: exactly at the threshold, then one pixel beyond.
    set_default();
    p_x[0] = 136; p_y[0] = 148;
    run_frame("ball_edge_in", 1'b1, 1'b0);
    set_default();
    p_x[0] = 137; p_y[0] = 148;
    run_frame("ball_edge_out", 1'b1, 1'b0);

    // Pin pair swap at exactly 2r, then just beyond.
    set_default();
    p_x[1] = 300; p_y[1] = 300; p_vx[1] = 2;  p_vy[1] = 0;
    p_x[2] = 342; p_y[2] = 300; p_vx[2] = -3; p_vy[2] = 1;
    run_frame("pair_in", 1'b1, 1'b0);
    p_x[2] = 343;
    run_frame("pair_out", 1'b1, 1'b0);

    // Ball result chained through a later pair swap.
    set_default();
    p_x[0] = 130; p_y[0] = 140;
    p_x[1] = 170; p_y[1] = 140; p_vx[1] = 1; p_vy[1] = 1;
    run_frame("chain", 1'b1, 1'b0);

    // Sticky: a hitless frame without clear keeps earlier hits.
    set_default();
    run_frame("sticky", 1'b0, 1'b0);
    bus.hit_clear_in = 1'b1;
    @(negedge clk_in);
    bus.hit_clear_in = 1'b0;
    exp_hit = '0;
    check("idle_clear/hit", bus.pins_hit, '0);

    // Off-lane overlaps: x beyond width, and y beyond height against on-lane pin.
    set_default();
    p_x[3] = 1100; p_y[3] = 500;
    p_x[4] = 1070; p_y[4] = 500;
    p_x[7] = 750;  p_y[7] = 740;
    p_x[8] = 760;  p_y[8] = 770;
    run_frame("offlane", 1'b0, 1'b0);

    // valid_in held through the busy period yields a single frame.
    set_default();
    p_x[0] = 130; p_y[0] = 140;
    run_frame("hold_valid", 1'b1, 1'b1);
    expect_no_done("hold_valid", 70);

    // Reset in cycle 20 of a frame aborts it.
    set_default();
    p_x[0] = 130; p_y[0] = 140;
    apply_inputs();
    bus.valid_in = 1'b1;
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    repeat (19) @(negedge clk_in);
    rst_in = 1'b1;
    #1 check("midrst/ready_in_rst", bus.ready_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_hit = '0;
    #1;
    check("midrst/ready", bus.ready_out, 1'b1);
    check("midrst/done", bus.done, 1'b0);
    check("midrst/vx", bus.pins_vx_out, '0);
    check("midrst/vy", bus.pins_vy_out, '0);
    check("midrst/hit", bus.pins_hit, '0);
    expect_no_done("midrst", 80);
    run_frame("after_rst", 1'b0, 1'b0);

    // Randomized crowded frames, some pins pushed off-lane.
    for (int f = 0; f < 12; f++) begin
      b_x  = $urandom_range(400, 60);
      b_y  = $urandom_range(400, 60);
      b_vx = int'($urandom_range(65535, 0)) - 32768;
      b_vy = int'($urandom_range(65535, 0)) - 32768;
      for (int k = 0; k < N; k++) begin
        p_x[k]  = ($urandom_range(9, 0) == 0) ? $urandom_range(1200, 1030) : $urandom_range(450, 40);
        p_y[k]  = ($urandom_range(9, 0) == 0) ? $urandom_range(900, 770)   : $urandom_range(450, 40);
        p_vx[k] = int'($urandom_range(65535, 0)) - 32768;
        p_vy[k] = int'($urandom_range(65535, 0)) - 32768;
      end
      run_frame($sformatf("rand%0d", f), 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
